// File: rtl/traffic_ctrl_param.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_param
//
// Two-way traffic-light controller. An internal prescaler divides clk down to
// a countdown tick. The phase sequence G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1
// includes an all-red clearance interval. Each direction shows a two-digit BCD
// countdown on active-low 7-segment displays. A hold input freezes the whole
// sequence.
//
// Optional feature, enabled by defining NIGHT_MODE_EN:
//   Adds the night input and a NIGHT phase in which both yellow lamps blink
//   and both displays are blank.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset (priority over hold/night)
//   hold           1 = freeze prescaler, phase and countdown
//   night          night-mode request (NIGHT_MODE_EN builds only)
//   xanh_1/2       green lamp, direction 1/2
//   vang_1/2       yellow lamp, direction 1/2
//   do_1/2         red lamp, direction 1/2
//   display_seg1/2 {tens[6:0], ones[6:0]}, active low; tens blank when zero
//   tick           one-cycle prescaler pulse
//
// Lamps and displays are a pure decode of the registered phase/pcnt. They
// change on the same edge as the state.
// -----------------------------------------------------------------------------
module traffic_ctrl_param #(
   parameter int unsigned CLK_HZ   = 125_000_000,
   parameter int unsigned TICK_HZ  = 1,
   parameter int unsigned GREEN_S  = 7,
   parameter int unsigned YELLOW_S = 3,
   parameter int unsigned ALLRED_S = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
`ifdef NIGHT_MODE_EN
   input  logic        night,
`endif
   output logic        xanh_1,
   output logic        vang_1,
   output logic        do_1,
   output logic        xanh_2,
   output logic        vang_2,
   output logic        do_2,
   output logic [13:0] display_seg1,
   output logic [13:0] display_seg2,
   output logic        tick
);

   // state    | meaning
   // ---------+-------------------------------------------
   // PH_G1    | direction 1 green, direction 2 red
   // PH_Y1    | direction 1 yellow, direction 2 red
   // PH_AR1   | all red, clearing before direction 2 green
   // PH_G2    | direction 2 green, direction 1 red (reset)
   // PH_Y2    | direction 2 yellow, direction 1 red
   // PH_AR2   | all red, clearing before direction 1 green
   // PH_NIGHT | both yellows blink on tick (NIGHT_MODE_EN)

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(DIV);

   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   localparam logic [6:0] DUR_G   = 7'(GREEN_S);
   localparam logic [6:0] DUR_Y   = 7'(YELLOW_S);
   localparam logic [6:0] DUR_AR  = 7'(ALLRED_S);
   // Offsets from pcnt to "ticks until my green starts" while red.
   localparam logic [6:0] OFS_YA  = 7'(YELLOW_S + ALLRED_S);
   localparam logic [6:0] OFS_GYA = 7'(GREEN_S + YELLOW_S + ALLRED_S);

   typedef enum logic [2:0] {
      PH_G1,
      PH_Y1,
      PH_AR1,
      PH_G2,
      PH_Y2,
      PH_AR2
`ifdef NIGHT_MODE_EN
      , PH_NIGHT
`endif
   } phase_t;

   phase_t        phase_q, phase_d;
   logic [6:0]    pcnt_q, pcnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          hold_eff;
   logic          tick_w;
`ifdef NIGHT_MODE_EN
   logic          blink_q, blink_d;
`endif

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         PH_G1:   return PH_Y1;
         PH_Y1:   return PH_AR1;
         PH_AR1:  return PH_G2;
         PH_G2:   return PH_Y2;
         PH_Y2:   return PH_AR2;
         default: return PH_G1;
      endcase
   endfunction

   function automatic logic [6:0] phase_dur(input phase_t p);
      case (p)
         PH_G1, PH_G2: return DUR_G;
         PH_Y1, PH_Y2: return DUR_Y;
         default:      return DUR_AR;
      endcase
   endfunction

   // Active-low segments, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [6:0] d);
      case (d)
         7'd0:    return 7'h40;
         7'd1:    return 7'h79;
         7'd2:    return 7'h24;
         7'd3:    return 7'h30;
         7'd4:    return 7'h19;
         7'd5:    return 7'h12;
         7'd6:    return 7'h02;
         7'd7:    return 7'h78;
         7'd8:    return 7'h00;
         7'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [13:0] to_disp(input logic [6:0] v);
      logic [6:0] tens;
      logic [6:0] ones;
      tens = v / 7'd10;
      ones = v % 7'd10;
      return {(tens == 7'd0) ? 7'h7F : seg7(tens), seg7(ones)};
   endfunction

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      hold_eff = hold;
`ifdef NIGHT_MODE_EN
      // Hold has no effect while blinking; the prescaler keeps running.
      if (phase_q == PH_NIGHT) hold_eff = 1'b0;
`endif
      tick_w  = (pre_q == PRE_MAX) && !hold_eff;
      pre_d   = (hold_eff || (pre_q == PRE_MAX)) ? '0 : pre_q + PW'(1);
      phase_d = phase_q;
      pcnt_d  = pcnt_q;
`ifdef NIGHT_MODE_EN
      blink_d = blink_q;
`endif
      if (tick_w) begin
`ifdef NIGHT_MODE_EN
         if (night) begin
            if (phase_q == PH_NIGHT) begin
               blink_d = ~blink_q;
            end else begin
               phase_d = PH_NIGHT;
               blink_d = 1'b1;
            end
         end else if (phase_q == PH_NIGHT) begin
            phase_d = PH_AR2;
            pcnt_d  = DUR_AR;
         end else
`endif
         if (pcnt_q == 7'd1) begin
            phase_d = next_phase(phase_q);
            pcnt_d  = phase_dur(next_phase(phase_q));
         end else begin
            pcnt_d  = pcnt_q - 7'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= PH_G2;
         pcnt_q  <= DUR_G;
         pre_q   <= '0;
`ifdef NIGHT_MODE_EN
         blink_q <= 1'b0;
`endif
      end else begin
         phase_q <= phase_d;
         pcnt_q  <= pcnt_d;
         pre_q   <= pre_d;
`ifdef NIGHT_MODE_EN
         blink_q <= blink_d;
`endif
      end
   end

   assign tick = tick_w;

   // -------------------------------------------------------------------------
   // Lamp and display decode
   // -------------------------------------------------------------------------
   logic [6:0] cd1, cd2;
   logic       blank;

   always_comb begin
      xanh_1 = 1'b0;
      vang_1 = 1'b0;
      do_1   = 1'b0;
      xanh_2 = 1'b0;
      vang_2 = 1'b0;
      do_2   = 1'b0;
      cd1    = pcnt_q;
      cd2    = pcnt_q;
      blank  = 1'b0;
      case (phase_q)
         PH_G1: begin
            xanh_1 = 1'b1;
            do_2   = 1'b1;
            cd2    = pcnt_q + OFS_YA;
         end
         PH_Y1: begin
            vang_1 = 1'b1;
            do_2   = 1'b1;
            cd2    = pcnt_q + DUR_AR;
         end
         PH_AR1: begin
            do_1   = 1'b1;
            do_2   = 1'b1;
            cd1    = pcnt_q + OFS_GYA;
         end
         PH_G2: begin
            do_1   = 1'b1;
            xanh_2 = 1'b1;
            cd1    = pcnt_q + OFS_YA;
         end
         PH_Y2: begin
            do_1   = 1'b1;
            vang_2 = 1'b1;
            cd1    = pcnt_q + DUR_AR;
         end
         PH_AR2: begin
            do_1   = 1'b1;
            do_2   = 1'b1;
            cd2    = pcnt_q + OFS_GYA;
         end
`ifdef NIGHT_MODE_EN
         PH_NIGHT: begin
            vang_1 = blink_q;
            vang_2 = blink_q;
            blank  = 1'b1;
         end
`endif
         default: begin
            do_1   = 1'b1;
            do_2   = 1'b1;
         end
      endcase
   end

   assign display_seg1 = blank ? 14'h3FFF : to_disp(cd1);
   assign display_seg2 = blank ? 14'h3FFF : to_disp(cd2);

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param with CLK_HZ=4, TICK_HZ=1, GREEN_S=7,
// YELLOW_S=3, ALLRED_S=1. The reference model views the light cycle as a
// 22-tick circle. Each direction owns a green+yellow window at a fixed offset
// on that circle, and its countdown is read off the circle position.
module tb_traffic_ctrl_param;

   localparam int DIVB = 4;
   localparam int G    = 7;
   localparam int Y    = 3;
   localparam int A    = 1;
   localparam int CYC  = 2 * (G + Y + A);
   localparam int S2   = 0;          // dir 2 green starts at circle position 0
   localparam int S1   = G + Y + A;  // dir 1 green starts half a circle later

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        hold = 1'b0;
   logic        night = 1'b0;
   logic        xanh_1, vang_1, do_1, xanh_2, vang_2, do_2, tick;
   logic [13:0] display_seg1, display_seg2;
   logic [5:0]  lamps;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int pos     = 0;   // model: ticks since reset, modulo CYC
   int pre     = 0;   // model: cycles since last tick/reset/hold
   bit chk_en  = 1'b0;

   traffic_ctrl_param #(
      .CLK_HZ(4), .TICK_HZ(1), .GREEN_S(G), .YELLOW_S(Y), .ALLRED_S(A)
   ) dut (
      .clk(clk),
      .reset(reset),
      .hold(hold),
`ifdef NIGHT_MODE_EN
      .night(night),
`endif
      .xanh_1(xanh_1), .vang_1(vang_1), .do_1(do_1),
      .xanh_2(xanh_2), .vang_2(vang_2), .do_2(do_2),
      .display_seg1(display_seg1), .display_seg2(display_seg2),
      .tick(tick)
   );

   always #5 clk = ~clk;

   assign lamps = {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2};

   function automatic logic [6:0] seg_ref(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tbl[d];
   endfunction

   function automatic logic [13:0] enc(input int v);
      return {(v / 10 == 0) ? 7'h7F : seg_ref(v / 10), seg_ref(v % 10)};
   endfunction

   // One direction on the circle: {green, yellow, red} lamps plus countdown.
   task automatic dir_ref(input int start, input int p, output logic [2:0] l, output int cd);
      int d;
      d = (p - start + CYC) % CYC;
      if (d < G) begin
         l = 3'b100; cd = G - d;
      end else if (d < G + Y) begin
         l = 3'b010; cd = G + Y - d;
      end else begin
         l = 3'b001; cd = CYC - d;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one clock cycle: inputs change at negedge, outputs checked 1 ns
   // later, model advanced at the following posedge.
   task automatic cycle(input logic r, input logic h);
      logic [2:0] l1, l2;
      int c1, c2;
      @(negedge clk);
      reset = r;
      hold  = h;
      #1;
      if (chk_en) begin
         dir_ref(S1, pos, l1, c1);
         dir_ref(S2, pos, l2, c2);
         chk("lamps", 32'(lamps), 32'({l1, l2}));
         chk("disp1", 32'(display_seg1), 32'(enc(c1)));
         chk("disp2", 32'(display_seg2), 32'(enc(c2)));
         chk("tick", 32'(tick), 32'((pre == DIVB - 1) && !h));
         chk("conflict", 32'((xanh_1 | vang_1) & (xanh_2 | vang_2)), 32'd0);
      end
      @(posedge clk);
      if (r) begin
         pos = 0;
         pre = 0;
      end else if (h) begin
         pre = 0;
      end else if (pre == DIVB - 1) begin
         pre = 0;
         pos = (pos + 1) % CYC;
      end else begin
         pre++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
   endtask

   initial begin
      // Step 1: reset for two cycles, then release.
      cycle(1'b1, 1'b0);
      chk_en = 1'b1;
      cycle(1'b1, 1'b0);
      #2;
      chk("rst_lamps", 32'(lamps), 32'b001100);
      chk("rst_disp1", 32'(display_seg1), 32'(enc(G + Y + A)));
      chk("rst_disp2", 32'(display_seg2), 32'({7'h7F, seg_ref(G)}));
      chk("rst_tick", 32'(tick), 32'd0);
      run(DIVB - 1);
      #2;
      chk("first_tick_pre", 32'(display_seg2), 32'(enc(G)));
      run(1);
      #2;
      chk("first_tick_post", 32'(display_seg2), 32'(enc(G - 1)));

      // Step 2: 7 ticks from reset lands in Y2.
      run(6 * DIVB);
      #2;
      chk("y2_lamps", 32'(lamps), 32'b001010);
      chk("y2_disp2", 32'(display_seg2), 32'(enc(3)));
      chk("y2_disp1", 32'(display_seg1), 32'(enc(4)));
      run(3 * DIVB);
      #2;
      chk("ar2_lamps", 32'(lamps), 32'b001001);
      chk("ar2_disp1", 32'(display_seg1), 32'(enc(1)));
      chk("ar2_disp2", 32'(display_seg2), 32'(enc(G + Y + A + 1)));
      run(DIVB);
      #2;
      chk("g1_lamps", 32'(lamps), 32'b100001);
      chk("g1_disp1", 32'(display_seg1), 32'(enc(7)));
      chk("g1_disp2", 32'(display_seg2), 32'(enc(Y + A + G)));

      // Step 3: two full cycles, checked every clock by the model.
      run(2 * CYC * DIVB);
      #2;
      chk("period_lamps", 32'(lamps), 32'b100001);

      // Step 4: hold mid-G1 at display1 = 5.
      run(2 * DIVB);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
      #2;
      chk("hold_disp1", 32'(display_seg1), 32'(enc(5)));
      chk("hold_lamps", 32'(lamps), 32'b100001);
      run(DIVB - 1);
      #2;
      chk("release_early", 32'(display_seg1), 32'(enc(5)));
      run(1);
      #2;
      chk("release_tick", 32'(display_seg1), 32'(enc(4)));

      // Step 5: reset in the middle of Y1.
      run(4 * DIVB + 2);
      #2;
      chk("mid_y1_lamps", 32'(lamps), 32'b010001);
      cycle(1'b1, 1'b0);
      #2;
      chk("rst2_lamps", 32'(lamps), 32'b001100);
      chk("rst2_disp1", 32'(display_seg1), 32'(enc(G + Y + A)));
      chk("rst2_disp2", 32'(display_seg2), 32'(enc(G)));

      // Randomized hold/reset traffic against the model.
      for (int i = 0; i < 700; i++) begin
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0);
      end

`ifdef NIGHT_MODE_EN
      // Step 6: night mode entry, blinking and exit to AR2.
      cycle(1'b1, 1'b0);
      run(CYC / 2 * DIVB);
      chk_en = 1'b0;
      night = 1'b1;
      run(DIVB);
      #2;
      chk("night_lamps", 32'(lamps), 32'b010010);
      chk("night_disp1", 32'(display_seg1), 32'h3FFF);
      chk("night_disp2", 32'(display_seg2), 32'h3FFF);
      cycle(1'b0, 1'b1);
      run(DIVB - 1);
      #2;
      chk("night_blink", 32'(lamps), 32'b000000);
      night = 1'b0;
      run(DIVB);
      #2;
      chk("night_exit_lamps", 32'(lamps), 32'b001001);
      chk("night_exit_disp1", 32'(display_seg1), 32'(enc(1)));
      pos = CYC / 2 - 1;
      pre = 0;
      chk_en = 1'b1;
      run(2 * DIVB);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
